// File: rtl/dmem_waitstate.sv
// Byte-addressed little-endian data memory with a req/ready handshake and WAIT_CYCLES wait states.
// Optional access counters (rd_count/wr_count) are built when DMEM_STATS_EN is defined.
module dmem_lane #(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);
  logic [LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module dmem_waitstate #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign,
`ifdef DMEM_STATS_EN
  output logic        oob,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`else
  output logic        oob
`endif
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                               state, state_nxt;
  logic [CNT_W-1:0]                     cnt, cnt_nxt;
  dmem_req_t                            cap_q, cur;
  logic                                 accept, mis, range_err, err, complete, wr_commit;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_LANES-1:0]                 lane_we, lane_sel;
  logic [NUM_LANES-1:0][LANE_W-1:0]     lane_wdata, lane_rdata;
  logic [31:0]                          rd_word, shifted, ld_data;

  // In IDLE the live inputs drive the checks so that an error or a
  // zero-wait access can complete on the capture edge itself.
  always_comb begin
    cur = cap_q;
    if (state == S_IDLE) begin
      cur.we       = we;
      cur.size     = size;
      cur.sign_ext = sign_ext;
      cur.addr     = addr;
      cur.wdata    = wdata;
    end
  end

  assign accept = (state == S_IDLE) && req;

  always_comb begin
    case (cur.size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = cur.addr[0];
      2'b10:   mis = |cur.addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  assign range_err = {2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err       = mis | range_err;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (mis || WAIT_CYCLES == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign complete = (state_nxt == S_DONE) && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cap_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) cap_q <= cur;
    end
  end

  assign ready = (state == S_DONE);
  assign busy  = (state != S_IDLE);

  // Byte-lane storage; a reset on the commit edge blocks the write.
  assign idx       = cur.addr[IDX_W+1:2];
  assign wr_commit = complete && cur.we && !err && !rst;

  always_comb begin
    case (cur.size)
      2'b00: begin
        lane_sel   = NUM_LANES'(1) << cur.addr[1:0];
        lane_wdata = {NUM_LANES{cur.wdata[7:0]}};
      end
      2'b01: begin
        lane_sel   = cur.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cur.wdata[15:0]}};
      end
      default: begin
        lane_sel   = 4'b1111;
        lane_wdata = cur.wdata;
      end
    endcase
    lane_we = lane_sel & {NUM_LANES{wr_commit}};
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_lane #(
      .DEPTH  (DEPTH_WORDS),
      .IDX_W  (IDX_W),
      .LANE_W (LANE_W)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[l]),
      .idx   (idx),
      .wdata (lane_wdata[l]),
      .rdata (lane_rdata[l])
    );
  end

  assign rd_word = lane_rdata;
  assign shifted = rd_word >> {cur.addr[1:0], 3'b000};

  always_comb begin
    case (cur.size)
      2'b00:   ld_data = cur.sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'h0, shifted[7:0]};
      2'b01:   ld_data = cur.sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                      : {16'h0, shifted[15:0]};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      misalign <= 1'b0;
      oob      <= 1'b0;
    end else begin
      misalign <= complete & mis;
      oob      <= complete & range_err;
      if (complete) rdata <= (cur.we || err) ? '0 : ld_data;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (complete && !err) begin
      if (cur.we) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dmem_waitstate.sv
// Directed bench for dmem_waitstate: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_dmem_waitstate;
  logic        clk = 1'b0;
  logic        rst, req, req_z, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata_z;
  logic        ready, busy, misalign, oob;
  logic        ready_z, busy_z, misalign_z, oob_z;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_waitstate #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
`ifdef DMEM_STATS_EN
    .misalign(misalign), .oob(oob), .rd_count(rd_count), .wr_count(wr_count)
`else
    .misalign(misalign), .oob(oob)
`endif
  );

  dmem_waitstate #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .CNT_W(8)) u_dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata_z), .ready(ready_z), .busy(busy_z),
`ifdef DMEM_STATS_EN
    .misalign(misalign_z), .oob(oob_z), .rd_count(), .wr_count()
`else
    .misalign(misalign_z), .oob(oob_z)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one request, then scramble the inputs so only captured values matter.
  task automatic xfer(input string tag, input bit z, input logic w, input logic [1:0] sz,
                      input logic sx, input logic [31:0] a, input logic [31:0] d,
                      input int elat, input logic [31:0] erd, input logic emis, input logic eoob);
    int lat;
    if (z) req_z = 1'b1; else req = 1'b1;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    step();
    req = 1'b0; req_z = 1'b0;
    we = ~w; size = ~sz; sign_ext = ~sx; addr = $urandom; wdata = $urandom;
    lat = 1;
    while (!(z ? ready_z : ready) && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".rdata"}, z ? rdata_z : rdata, erd);
    chk({tag, ".misalign"}, 32'(z ? misalign_z : misalign), 32'(emis));
    chk({tag, ".oob"}, 32'(z ? oob_z : oob), 32'(eoob));
    step();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_z = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) step();
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.ready", 32'(ready), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.misalign", 32'(misalign), 32'h0);
    chk("rst.oob", 32'(oob), 32'h0);
    rst = 1'b0;
    step();

    // word round trip and little-endian byte/half access
    xfer("st_w0",   0, 1, 2'b10, 0, 32'h0,  32'h0BADF00D, 3, 32'h0, 0, 0);
    xfer("st_w10",  0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 3, 32'h0, 0, 0);
    xfer("ld_w10",  0, 0, 2'b10, 0, 32'h10, 32'h0,        3, 32'hDEADBEEF, 0, 0);
    xfer("st_b13",  0, 1, 2'b00, 0, 32'h13, 32'hAAAAAA80, 3, 32'h0, 0, 0);
    xfer("ld_b13s", 0, 0, 2'b00, 1, 32'h13, 32'h0,        3, 32'hFFFFFF80, 0, 0);
    xfer("ld_b13u", 0, 0, 2'b00, 0, 32'h13, 32'h0,        3, 32'h00000080, 0, 0);
    xfer("ld_w10b", 0, 0, 2'b10, 0, 32'h10, 32'h0,        3, 32'h80ADBEEF, 0, 0);
    xfer("ld_b11s", 0, 0, 2'b00, 1, 32'h11, 32'h0,        3, 32'hFFFFFFBE, 0, 0);
    xfer("ld_h12s", 0, 0, 2'b01, 1, 32'h12, 32'h0,        3, 32'hFFFF80AD, 0, 0);
    xfer("ld_h12u", 0, 0, 2'b01, 0, 32'h12, 32'h0,        3, 32'h000080AD, 0, 0);
    xfer("st_h10",  0, 1, 2'b01, 0, 32'h10, 32'h55551234, 3, 32'h0, 0, 0);
    xfer("ld_w10c", 0, 0, 2'b10, 0, 32'h10, 32'h0,        3, 32'h80AD1234, 0, 0);

    // misaligned: immediate completion, no side effects, flag clears next cycle
    req = 1'b1; we = 1'b0; size = 2'b01; sign_ext = 1'b0; addr = 32'h11;
    step();
    req = 1'b0;
    chk("mis_h11.ready", 32'(ready), 32'h1);
    chk("mis_h11.misalign", 32'(misalign), 32'h1);
    chk("mis_h11.rdata", rdata, 32'h0);
    step();
    chk("mis_h11.clear", 32'(misalign), 32'h0);
    chk("mis_h11.idle", 32'(busy), 32'h0);
    step();
    xfer("mis_sw12", 0, 1, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 1, 32'h0, 1, 0);
    xfer("mis_sz3",  0, 0, 2'b11, 0, 32'h10, 32'h0,        1, 32'h0, 1, 0);
    xfer("ld_w10d",  0, 0, 2'b10, 0, 32'h10, 32'h0,        3, 32'h80AD1234, 0, 0);

    // range boundary; 0x1000 would alias word 0 if the write were not suppressed
    xfer("st_ffc",  0, 1, 2'b10, 0, 32'hFFC,  32'h12345678, 3, 32'h0, 0, 0);
    xfer("oob_st",  0, 1, 2'b10, 0, 32'h1000, 32'hCAFEBABE, 3, 32'h0, 0, 1);
    xfer("oob_ld",  0, 0, 2'b10, 0, 32'h1000, 32'h0,        3, 32'h0, 0, 1);
    xfer("ld_ffc",  0, 0, 2'b10, 0, 32'hFFC,  32'h0,        3, 32'h12345678, 0, 0);
    xfer("ld_w0",   0, 0, 2'b10, 0, 32'h0,    32'h0,        3, 32'h0BADF00D, 0, 0);

    // req pulse during WAIT is ignored
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
    step();
    we = 1'b1; addr = 32'h10; wdata = 32'h0;
    step();
    req = 1'b0;
    chk("ign.wait_busy", 32'(busy), 32'h1);
    chk("ign.wait_ready", 32'(ready), 32'h0);
    step();
    chk("ign.ready", 32'(ready), 32'h1);
    chk("ign.rdata", rdata, 32'h80AD1234);
    step();
    chk("ign.idle", 32'(busy), 32'h0);
    xfer("ld_w10e", 0, 0, 2'b10, 0, 32'h10, 32'h0, 3, 32'h80AD1234, 0, 0);

    // reset in the second WAIT cycle abandons the store
    xfer("st_w20", 0, 1, 2'b10, 0, 32'h20, 32'h11111111, 3, 32'h0, 0, 0);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h22222222;
    step();
    req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid.busy", 32'(busy), 32'h0);
    chk("rstmid.ready", 32'(ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstmid.no_ready", 32'(ready), 32'h0);
    end
    xfer("ld_w20", 0, 0, 2'b10, 0, 32'h20, 32'h0, 3, 32'h11111111, 0, 0);

    // zero-wait instance
    xfer("z_st_w4",  1, 1, 2'b10, 0, 32'h4, 32'hA5A5C3C3, 1, 32'h0, 0, 0);
    xfer("z_ld_b5",  1, 0, 2'b00, 1, 32'h5, 32'h0,        1, 32'hFFFFFFC3, 0, 0);
    xfer("z_ld_w4",  1, 0, 2'b10, 0, 32'h4, 32'h0,        1, 32'hA5A5C3C3, 0, 0);
    xfer("z_oob",    1, 0, 2'b10, 0, 32'h2000, 32'h0,     1, 32'h0, 0, 1);
    chk("z_idle", 32'(busy_z), 32'h0);

`ifdef DMEM_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stats.rst_rd", 32'(rd_count), 32'h0);
    chk("stats.rst_wr", 32'(wr_count), 32'h0);
    xfer("s_ld0", 0, 0, 2'b10, 0, 32'h10,  32'h0, 3, 32'h80AD1234, 0, 0);
    xfer("s_st0", 0, 1, 2'b10, 0, 32'h24,  32'h1, 3, 32'h0, 0, 0);
    xfer("s_ld1", 0, 0, 2'b10, 0, 32'hFFC, 32'h0, 3, 32'h12345678, 0, 0);
    xfer("s_mis", 0, 0, 2'b01, 0, 32'h11,  32'h0, 1, 32'h0, 1, 0);
    xfer("s_st1", 0, 1, 2'b10, 0, 32'h28,  32'h2, 3, 32'h0, 0, 0);
    xfer("s_ld2", 0, 0, 2'b10, 0, 32'h0,   32'h0, 3, 32'h0BADF00D, 0, 0);
    chk("stats.rd", 32'(rd_count), 32'd3);
    chk("stats.wr", 32'(wr_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stats.clr_rd", 32'(rd_count), 32'h0);
    chk("stats.clr_wr", 32'(wr_count), 32'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
